ram_req_rsp: RTL and testbench
==============================

// Module: ram_req_rsp
// PURPOSE
//  Parametrised single-port word RAM with per-byte write strobes, valid/ready request and
//  response channels, configurable read latency and out-of-range error reporting.
//  Successor to the combinational-read byte RAM; serves core LSU / bus slave ports that
//  need pipelined, back-pressured, in-order access.
// PARAMETERS
//  XLEN       32  data width in bits; multiple of 8, >= 8
//  MEM_WORDS  64  depth in XLEN-bit words; >= 2
//  READ_LAT   1   request-accept to response-available cycles; 1..4
//  ADDR_W     32  byte address width
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          asynchronous, active-high reset
//  ce_i         in   1          chip enable; 0 blocks new request acceptance
//  req_valid_i  in   1          request valid
//  req_ready_o  out  1          request ready
//  req_we_i     in   1          1 = write, 0 = read
//  req_addr_i   in   ADDR_W     byte address; low log2(XLEN/8) bits ignored (word-aligned)
//  req_strb_i   in   XLEN/8     byte strobes; bit i -> data[8i+7:8i]; ignored on reads
//  req_wdata_i  in   XLEN       write data
//  rsp_valid_o  out  1          response valid
//  rsp_ready_i  in   1          response ready
//  rsp_rdata_o  out  XLEN       read data; 0 for writes and errors
//  rsp_err_o    out  1          word index >= MEM_WORDS
// BEHAVIOUR
//  - Reset: req_ready_o=0 during reset, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0,
//    outstanding count=0, pipeline and FIFO flushed. Memory contents NOT reset.
//  - Reset mid-operation: all in-flight and buffered responses dropped; no partial write.
//  - Accept: req_valid_i & req_ready_o at rising edge. req_ready_o = ce_i & (outst < RSP_DEPTH),
//    RSP_DEPTH = READ_LAT+1; outst = accepted-but-not-yet-delivered responses.
//  - outst update: +1 on accept, -1 on rsp_valid_o & rsp_ready_i; both same cycle -> unchanged.
//  - Word index = req_addr_i >> log2(XLEN/8). index >= MEM_WORDS -> error: no write, response
//    rsp_err_o=1, rsp_rdata_o=0.
//  - Write: bytes with strobe=1 updated at the accept edge; strobe=0 bytes unchanged;
//    strb=0 -> no-op but still responds (err=0). Every write yields one response.
//  - Read: data sampled at accept edge (sees all previously accepted writes); response
//    enters response FIFO READ_LAT cycles after accept (READ_LAT=1 -> rsp_valid_o high the
//    cycle after accept when FIFO empty).
//  - Responses strictly in request order; pipeline never stalls (FIFO sized to absorb all
//    in-flight), so rsp_ready_i low only blocks new accepts via outst.
//  - rsp_* held stable while rsp_valid_o & !rsp_ready_i.
//  - Throughput: 1 req/cycle sustained with rsp_ready_i=1.
//  - ce_i=0: no accepts; in-flight responses still drain.
// STRUCTURE
//  - ram_pkg: clog2 function, BYTE_W=8 constant, response record (rdata, err) width helper.
//  - Sub-module ram_rsp_fifo: synchronous FIFO, depth RSP_DEPTH, width XLEN+1, async reset,
//    full/empty flags, wrap-around pointers with extra MSB.
//  - Top: storage array, READ_LAT-stage valid/data shift pipeline, outstanding counter.
// TESTING
//  - Write 0xDEADBEEF to 0x10, strb=4'hF, then read 0x10 -> rdata 0xDEADBEEF, err=0.
//  - Preload 0x11223344 @0x08; write 0xAABBCCDD strb=4'b0101 -> read gives 0x11BB33DD.
//  - Read addr 0x13 -> same word as 0x10 (low bits ignored); read 4*MEM_WORDS -> err=1, rdata 0.
//  - READ_LAT=3, hold rsp_ready_i=0, stream reads -> exactly 4 accepted, req_ready_o=0,
//    then release -> 4 responses in order, no loss/duplication.
//  - Back-to-back write then read same addr, rsp_ready_i=1 -> read returns new data;
//    1 accept/cycle sustained.
//  - Assert rst_i with 3 outstanding -> rsp_valid_o=0 immediately; after release outst=0,
//    memory retains prior writes.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and sizing helpers for the request/response RAM
package ram_pkg;
  localparam int BYTE_W = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int rsp_w(input int xlen);
    return xlen + 1;
  endfunction
endpackage

// File: rtl/ram_rsp_fifo.sv
// ram_rsp_fifo: small synchronous response FIFO with wrap-around pointers carrying an extra lap bit
module ram_rsp_fifo
  import ram_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = clog2(2 * DEPTH);
  localparam int IW = clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  function automatic logic [IW-1:0] slot(input logic [PW-1:0] p);
    return IW'(p >= PW'(DEPTH) ? p - PW'(DEPTH) : p);
  endfunction
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return p == PW'(2 * DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = wp == rp;
  assign full  = !empty && slot(wp) == slot(rp);
  assign dout  = mem[slot(rp)];
  // pointers run over two laps so equal slots distinguish full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= bump(wp);
      if (pop) rp <= bump(rp);
    end
  end
  // storage needs no reset: empty masks stale entries at the output
  always_ff @(posedge clk) begin
    if (push) mem[slot(wp)] <= din;
  end
endmodule

// File: rtl/ram_req_rsp.sv
// ram_req_rsp: byte-strobed word RAM with valid/ready channels, fixed read latency and range errors
module ram_req_rsp
  import ram_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 64,
  parameter int READ_LAT  = 1,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ce_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [ADDR_W-1:0]      req_addr_i,
  input  logic [XLEN/BYTE_W-1:0] req_strb_i,
  input  logic [XLEN-1:0]        req_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [XLEN-1:0]        rsp_rdata_o,
  output logic                   rsp_err_o
);
  localparam int BYTES     = XLEN / BYTE_W;
  localparam int OFF_W     = clog2(BYTES);
  localparam int IW        = clog2(MEM_WORDS);
  localparam int RSP_DEPTH = READ_LAT + 1;
  localparam int RW        = rsp_w(XLEN);
  localparam int CW        = clog2(RSP_DEPTH + 1);
  logic [XLEN-1:0] mem [MEM_WORDS];
  logic [ADDR_W-1:0] word;
  logic [IW-1:0] idx;
  logic err, acc, pop, push, fifo_full, fifo_empty;
  logic [RW-1:0] in_d, push_d, head;
  logic [CW-1:0] outst;
  assign word        = req_addr_i >> OFF_W;
  assign err         = word >= ADDR_W'(MEM_WORDS);
  assign idx         = word[IW-1:0];
  assign req_ready_o = ce_i & !rst_i & (outst < CW'(RSP_DEPTH));
  assign acc         = req_valid_i & req_ready_o;
  assign in_d        = {err, (err | req_we_i) ? '0 : mem[idx]};
  assign rsp_valid_o = !fifo_empty;
  assign rsp_rdata_o = fifo_empty ? '0 : head[XLEN-1:0];
  assign rsp_err_o   = !fifo_empty & head[XLEN];
  assign pop         = rsp_valid_o & rsp_ready_i;
  // strobed byte writes at the accept edge; out-of-range and reset-time requests never write
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BYTES; b++)
      if (acc & req_we_i & !err & req_strb_i[b]) mem[idx][b*BYTE_W +: BYTE_W] <= req_wdata_i[b*BYTE_W +: BYTE_W];
  end
  // responses owed to the requester, bounding what the FIFO must ever hold
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) outst <= '0;
    else outst <= outst + CW'(acc) - CW'(pop);
  end
  if (READ_LAT == 1) begin : g_direct
    assign push   = acc;
    assign push_d = in_d;
  end else begin : g_pipe
    logic [READ_LAT-1:1] sv;
    logic [RW-1:0] sd [1:READ_LAT-1];
    // fixed-length delay line; the FIFO write is the final stage of the latency
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sv <= '0;
        for (int k = 1; k < READ_LAT; k++) sd[k] <= '0;
      end else begin
        sv[1] <= acc;
        sd[1] <= in_d;
        for (int k = 2; k < READ_LAT; k++) begin
          sv[k] <= sv[k-1];
          sd[k] <= sd[k-1];
        end
      end
    end
    assign push   = sv[READ_LAT-1];
    assign push_d = sd[READ_LAT-1];
  end
  ram_rsp_fifo #(.DEPTH(RSP_DEPTH), .W(RW)) u_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (push & !fifo_full),
    .pop  (pop),
    .din  (push_d),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_ram_req_rsp.sv
// tb_ram_req_rsp: directed stimulus with a queue scoreboard checked by an independent response monitor
module tb_ram_req_rsp;
  localparam int LAT = 3;
  logic clk = 0, rst = 1, ce = 1, req_valid = 0, req_we = 0, rsp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0] req_strb = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [32:0] q[$];
  logic [32:0] exp_head;
  int checks = 0, errors = 0, cyc = 0, accepts = 0, rsp_cnt = 0, acc_cyc = 0;

  ram_req_rsp #(.XLEN(32), .MEM_WORDS(64), .READ_LAT(LAT), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_strb_i(req_strb), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (!rst && req_valid && req_ready) accepts++;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got err=%0b rdata=%0h expected no response", rsp_err, rsp_rdata);
      end else begin
        exp_head = q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(exp_head[32]));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_head[31:0]));
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input logic [32:0] e);
    int n = 0;
    req_valid = 1; req_we = we; req_addr = a; req_strb = s; req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready=0 required 1 for addr %0h", a);
    end else q.push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int n, c1, k, a0, r0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 0);
    chk("reset_rsp_valid", 64'(rsp_valid), 0);
    chk("reset_rsp_rdata", 64'(rsp_rdata), 0);
    chk("reset_rsp_err", 64'(rsp_err), 0);
    rst = 0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 64'(req_ready), 1);
    send(1, 32'h10, 4'hF, 32'hDEADBEEF, {1'b0, 32'h0});
    send(0, 32'h10, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF});
    send(1, 32'h08, 4'hF, 32'h11223344, {1'b0, 32'h0});
    send(1, 32'h08, 4'b0101, 32'hAABBCCDD, {1'b0, 32'h0});
    send(0, 32'h08, 4'h0, 32'h0, {1'b0, 32'h11BB33DD});
    send(0, 32'h13, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF});
    send(0, 32'h100, 4'h0, 32'h0, {1'b1, 32'h0});
    send(1, 32'h100, 4'hF, 32'hFFFFFFFF, {1'b1, 32'h0});
    send(1, 32'h10, 4'h0, 32'h12345678, {1'b0, 32'h0});
    send(0, 32'h10, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF});
    send(1, 32'hFC, 4'hF, 32'h55AA55AA, {1'b0, 32'h0});
    send(0, 32'hFE, 4'h0, 32'h0, {1'b0, 32'h55AA55AA});
    drain();
    send(0, 32'h10, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF});
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("read_latency", 64'(n), LAT);
    drain();
    send(1, 32'h30, 4'hF, 32'hCAFEF00D, {1'b0, 32'h0});
    c1 = acc_cyc;
    send(0, 32'h30, 4'h0, 32'h0, {1'b0, 32'hCAFEF00D});
    send(1, 32'h30, 4'b1000, 32'h12000000, {1'b0, 32'h0});
    send(0, 32'h30, 4'h0, 32'h0, {1'b0, 32'h12FEF00D});
    chk("b2b_cycles", 64'(acc_cyc - c1), 3);
    drain();
    for (int i = 0; i < 4; i++) send(1, 32'h20 + 32'(4 * i), 4'hF, 32'hA0A00000 | 32'(i), {1'b0, 32'h0});
    drain();
    rsp_ready = 0;
    r0 = rsp_cnt;
    k = 0;
    req_valid = 1; req_we = 0;
    for (int c = 0; c < 10; c++) begin
      req_addr = 32'h20 + 32'(4 * (k % 4));
      @(negedge clk);
      if (req_ready) begin
        q.push_back({1'b0, 32'hA0A00000 | 32'(k % 4)});
        k++;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 0;
    chk("stall_accepts", 64'(k), 4);
    chk("stall_ready", 64'(req_ready), 0);
    chk("stall_rsp_held", 64'(rsp_rdata), 32'hA0A00000);
    rsp_ready = 1;
    drain();
    chk("stall_rsp_count", 64'(rsp_cnt - r0), 4);
    ce = 0;
    a0 = accepts;
    req_valid = 1; req_addr = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("ce_ready", 64'(req_ready), 0);
    chk("ce_accepts", 64'(accepts - a0), 0);
    req_valid = 0;
    ce = 1;
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) send(0, 32'h10, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF});
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_valid", 64'(rsp_valid), 1);
    rst = 1;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 1);
    for (int i = 0; i < 4; i++) send(0, 32'h10, 4'h0, 32'h0, {1'b0, 32'hDEADBEEF});
    chk("post_rst_full", 64'(req_ready), 0);
    rsp_ready = 1;
    drain();
    send(0, 32'h08, 4'h0, 32'h0, {1'b0, 32'h11BB33DD});
    send(0, 32'h24, 4'h0, 32'h0, {1'b0, 32'hA0A00001});
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
